rcs_seq_ctrl: RTL and testbench
===============================

RCS_SEQ_CTRL -- requirements
Module: rcs_seq_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of 16-bit words per operand (legal 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one subtraction; sampled only when idle or done.
REQ-005 SHALL have port a  input  16*WORDS  minuend.
REQ-006 SHALL have port b  input  16*WORDS  subtrahend.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when diff is valid.
REQ-009 SHALL have port diff  output  16*WORDS  registered result a-b, modulo 2^(16*WORDS).
REQ-010 SHALL have port borrow  output  1  unsigned borrow out (1 when a<b).
REQ-011 SHALL have port ovf  output  1  signed two's-complement overflow flag (see Configuration).

Function
REQ-012 SHALL time-multiplex one internal 16-bit ripple-carry subtract slice: diff_w = a_w + ~b_w + cin, cout = carry-out; cout=1 means no borrow.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE/DONE with start=1: SHALL latch a and b into internal registers, clear word index to 0, set carry register to 1, enter RUN, assert busy next cycle.
REQ-015 IDLE/DONE with start=0: DONE SHALL go to IDLE after one cycle; IDLE SHALL stay.
REQ-016 RUN: each cycle SHALL process word idx (bits 16*idx+15:16*idx), write slice result into diff word idx, load carry register with cout, increment idx.
REQ-017 RUN SHALL last exactly WORDS cycles, least-significant word first; after word WORDS-1 SHALL enter DONE.
REQ-018 DONE: done=1 and busy=0 for exactly that cycle; borrow = inverse of final carry register.
REQ-019 Latency: start sampled at edge T -> done high in cycle after edge T+WORDS (done seen at edge T+WORDS+1).
REQ-020 start while in RUN SHALL be ignored; latched operands and progress SHALL be unaffected; a/b changes during RUN SHALL not affect the result.
REQ-021 start in DONE cycle SHALL be accepted (back-to-back ops, no idle gap); done SHALL still pulse for the finished op.
REQ-022 diff, borrow, ovf SHALL hold their last final values from DONE until the next accepted start; intermediate diff words MAY change during RUN.
REQ-023 Word index SHALL not wrap within an op; idx width = ceil(log2(WORDS))+1.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, idx=0, carry register=1, busy=0, done=0, diff=0, borrow=0, ovf=0.
REQ-025 rst SHALL take priority over start and abort any op in RUN; no done pulse SHALL follow an aborted op.

Configuration
REQ-026 Macro RCS_SEQ_CTRL_OVF_EN defined: ovf SHALL be registered at DONE entry as (a_msb != b_msb) && (diff_msb != a_msb) using latched operands.
REQ-027 Macro RCS_SEQ_CTRL_OVF_EN undefined: ovf port SHALL remain and be tied constant 0; no overflow logic synthesized.

Verification (WORDS=4)
REQ-028 a=0x0000000000000005, b=0x3, start 1 cycle -> done 5 edges later, diff=0x0000000000000002, borrow=0, busy high 4 cycles.
REQ-029 a=0x0, b=0x1 -> diff=0xFFFFFFFFFFFFFFFF, borrow=1; a=0x0000000000010000, b=0x1 -> diff=0x000000000000FFFF, borrow=0 (cross-word borrow).
REQ-030 a=0x8000000000000000, b=0x1 -> diff=0x7FFFFFFFFFFFFFFF, borrow=0, ovf=1 with RCS_SEQ_CTRL_OVF_EN, ovf=0 without.
REQ-031 start pulsed again at 2nd RUN cycle with different a/b -> ignored, result matches first op; start held high during DONE -> second op starts, two done pulses 5 cycles apart.
REQ-032 rst asserted in 3rd RUN cycle -> next cycle busy=0, diff=0, no done pulse; subsequent start gives correct result.

Source files
------------

// File: rtl/rcs_seq_ctrl.sv
// rcs_seq_ctrl: word-serial multi-word subtractor (a - b) built from one 16-bit slice.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, diff, borrow, ovf.
// Define RCS_SEQ_CTRL_OVF_EN to enable signed overflow; otherwise ovf is tied to 0.
module rcs_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   diff,
  output logic                  borrow,
  output logic                  ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;

  logic [15:0]     a_w, b_w;
  logic [16:0]     sum;
  logic            last;

  // Select the current word from the latched operands.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        a_w = a_q[16*i +: 16];
        b_w = b_q[16*i +: 16];
      end
    end
  end

  // Subtract as a + ~b + cin; carry out of 1 means no borrow.
  assign sum  = {1'b0, a_w} + {1'b0, ~b_w} + {16'b0, carry_q};
  assign last = (idx_q == IW'(WORDS - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) diff_d[16*i +: 16] = sum[15:0];
        end
        carry_d = sum[16];
        idx_d   = idx_q + IW'(1);
        if (last) begin
          borrow_d = ~sum[16];
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef RCS_SEQ_CTRL_OVF_EN
  logic ovf_q, ovf_d;

  // Captured with the top word so it is valid on DONE entry.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last) begin
      ovf_d = (a_q[W-1] != b_q[W-1]) && (sum[15] != a_q[W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_rcs_seq_ctrl.sv
// tb_rcs_seq_ctrl: randomized self-checking bench for rcs_seq_ctrl (WORDS=4).
// Compares against a 64/65-bit arithmetic reference model.
module tb_rcs_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow, ovf;

  int checks = 0;
  int passed = 0;

  rcs_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void model(
    input  logic [W-1:0] va,
    input  logic [W-1:0] vb,
    output logic [W-1:0] ed,
    output logic         eb,
    output logic         eo
  );
    logic [W:0] full;
    ed   = va - vb;
    eb   = (va < vb);
    full = {va[W-1], va} - {vb[W-1], vb};
    eo   = (full[W] != full[W-1]);
`ifndef RCS_SEQ_CTRL_OVF_EN
    eo   = 1'b0;
`endif
  endfunction

  // Issue one op, scramble inputs while running, wait (bounded) for done.
  task automatic run_op(
    input  logic [W-1:0] va,
    input  logic [W-1:0] vb,
    output int           lat,
    output int           nbusy
  );
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rnd64(); b = rnd64();
    lat = 0; nbusy = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (diff !== '0) $display("FAIL reset_diff: got %h want 0", diff); else passed++;
    checks++; if (borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", borrow); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [$];
    logic [W-1:0] vb [$];
    logic [W-1:0] ed;
    logic eb, eo;
    int lat, nb;
    va.push_back(64'h5);                 vb.push_back(64'h3);
    va.push_back(64'h0);                 vb.push_back(64'h1);
    va.push_back(64'h0000000000010000);  vb.push_back(64'h1);
    va.push_back(64'h8000000000000000);  vb.push_back(64'h1);
    va.push_back(64'h7FFFFFFFFFFFFFFF);  vb.push_back(64'hFFFFFFFFFFFFFFFF);
    va.push_back(64'hFFFFFFFFFFFFFFFF);  vb.push_back(64'hFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 14; i++) begin
      va.push_back(rnd64()); vb.push_back(rnd64());
    end
    for (int i = 0; i < va.size(); i++) begin
      model(va[i], vb[i], ed, eb, eo);
      run_op(va[i], vb[i], lat, nb);
      checks++; if (lat !== WORDS) $display("FAIL op%0d_latency: got %0d want %0d", i, lat, WORDS); else passed++;
      checks++; if (nb !== WORDS) $display("FAIL op%0d_busy_cycles: got %0d want %0d", i, nb, WORDS); else passed++;
      checks++; if (diff !== ed) $display("FAIL op%0d_diff: got %h want %h", i, diff, ed); else passed++;
      checks++; if (borrow !== eb) $display("FAIL op%0d_borrow: got %b want %b", i, borrow, eb); else passed++;
      checks++; if (ovf !== eo) $display("FAIL op%0d_ovf: got %b want %b", i, ovf, eo); else passed++;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) $display("FAIL op%0d_done_pulse: got %b want 0", i, done); else passed++;
      checks++; if (diff !== ed) $display("FAIL op%0d_diff_hold: got %h want %h", i, diff, ed); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] va, vb, ed;
    logic eb, eo;
    int lat;
    va = rnd64(); vb = rnd64();
    model(va, vb, ed, eb, eo);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = rnd64(); b = rnd64(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== WORDS) $display("FAIL ignore_latency: got %0d want %0d", lat, WORDS); else passed++;
    checks++; if (diff !== ed) $display("FAIL ignore_diff: got %h want %h", diff, ed); else passed++;
    checks++; if (borrow !== eb) $display("FAIL ignore_borrow: got %b want %b", borrow, eb); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v1a, v1b, v2a, v2b, e1, e2;
    logic eb1, eo1, eb2, eo2;
    int lat, nb, gap;
    v1a = rnd64(); v1b = rnd64();
    v2a = rnd64(); v2b = rnd64();
    model(v1a, v1b, e1, eb1, eo1);
    model(v2a, v2b, e2, eb2, eo2);
    run_op(v1a, v1b, lat, nb);
    checks++; if (diff !== e1) $display("FAIL b2b_first_diff: got %h want %h", diff, e1); else passed++;
    a = v2a; b = v2b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", busy); else passed++;
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    checks++; if (gap !== WORDS + 1) $display("FAIL b2b_done_gap: got %0d want %0d", gap, WORDS + 1); else passed++;
    checks++; if (diff !== e2) $display("FAIL b2b_second_diff: got %h want %h", diff, e2); else passed++;
    checks++; if (borrow !== eb2) $display("FAIL b2b_second_borrow: got %b want %b", borrow, eb2); else passed++;
    checks++; if (ovf !== eo2) $display("FAIL b2b_second_ovf: got %b want %b", ovf, eo2); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_abort();
    logic [W-1:0] va, vb, ed;
    logic eb, eo;
    int lat, nb, seen;
    a = rnd64(); b = rnd64(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    checks++; if (diff !== '0) $display("FAIL abort_diff: got %h want 0", diff); else passed++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", seen); else passed++;
    va = rnd64(); vb = rnd64();
    model(va, vb, ed, eb, eo);
    run_op(va, vb, lat, nb);
    checks++; if (lat !== WORDS) $display("FAIL abort_next_latency: got %0d want %0d", lat, WORDS); else passed++;
    checks++; if (diff !== ed) $display("FAIL abort_next_diff: got %h want %h", diff, ed); else passed++;
    checks++; if (borrow !== eb) $display("FAIL abort_next_borrow: got %b want %b", borrow, eb); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_rst_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
